signal_engine: RTL

SIGNAL_ENGINE -- requirements
Module: signal_engine

---
 rtl/fxp_pkg.sv | 28 ++
 rtl/signal_engine_if.sv | 25 ++
 rtl/signal_engine.sv | 106 ++++++++++
 3 files changed

// File: rtl/fxp_pkg.sv
// Q16.16 fixed-point helpers and the position encoding shared by the signal engine
// and anything that consumes its output.
package fxp_pkg;

    localparam int unsigned Q_FRAC_BITS = 16;
    localparam logic signed [31:0] Q_ZERO = 32'sh0000_0000;
    localparam logic signed [31:0] Q_ONE  = 32'sh0001_0000;
    localparam logic signed [31:0] Q_MAX  = 32'sh7FFF_FFFF;
    localparam logic signed [31:0] Q_MIN  = 32'sh8000_0000;

    typedef enum logic [1:0] {
        FLAT  = 2'b00,
        LONG  = 2'b01,
        SHORT = 2'b10
    } pos_t;

    // Add in 33 bits; a sign/carry disagreement means overflow toward sum[32]'s side.
    function automatic logic signed [31:0] sat32(input logic signed [31:0] a,
                                                 input logic signed [31:0] b);
        logic [32:0] sum;
        sum = {a[31], a} + {b[31], b};
        if (sum[32] != sum[31]) begin
            return sum[32] ? Q_MIN : Q_MAX;
        end
        return sum[31:0];
    endfunction

endpackage

// File: rtl/signal_engine_if.sv
// Stream bundle for the signal engine: feature samples in, scored positions out.
interface signal_engine_if;

    logic               in_valid;
    logic               in_ready;
    logic signed [31:0] ret_in;
    logic signed [31:0] ema_in;

    logic               out_valid;
    logic               out_ready;
    logic signed [31:0] score_out;
    logic [1:0]         pos_out;
    logic               trade_out;

    modport slave (
        input  in_valid, ret_in, ema_in, out_ready,
        output in_ready, out_valid, score_out, pos_out, trade_out
    );

    modport master (
        output in_valid, ret_in, ema_in, out_ready,
        input  in_ready, out_valid, score_out, pos_out, trade_out
    );

endinterface

// File: rtl/signal_engine.sv
// Scores each accepted sample, runs the FLAT/LONG/SHORT hysteresis FSM with a
// post-trade cooldown, and holds the result in a one-entry output register.
module signal_engine
    import fxp_pkg::*;
#(
    parameter logic signed [31:0] ENTRY_TH  = 32'sh0000_4000,
    parameter logic signed [31:0] EXIT_TH   = 32'sh0000_1000,
    parameter int unsigned        RET_SHIFT = 2,
    parameter int unsigned        COOLDOWN  = 4
) (
    input logic             clk,
    input logic             rst,
    signal_engine_if.slave  bus
);

    // Width is forced to at least 1 so COOLDOWN=0 still elaborates; the load value is then 0.
    localparam int unsigned CNT_W = (COOLDOWN > 0) ? $clog2(COOLDOWN + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(COOLDOWN);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    localparam logic signed [31:0] NEG_ENTRY_TH = -ENTRY_TH;
    localparam logic signed [31:0] NEG_EXIT_TH  = -EXIT_TH;

    logic               out_valid_q;
    logic signed [31:0] score_q;
    pos_t               pos_q;
    logic               trade_q;
    logic [CNT_W-1:0]   cnt_q;

    logic               accept;
    logic               consume;
    logic               ready;

    logic signed [31:0] score_c;
    pos_t               pos_c;
    logic               trade_c;
    logic [CNT_W-1:0]   cnt_c;

    assign ready   = !out_valid_q || bus.out_ready;
    assign accept  = bus.in_valid && ready;
    assign consume = out_valid_q && bus.out_ready;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        score_c = sat32(bus.ema_in, bus.ret_in >>> RET_SHIFT);
        pos_c   = pos_q;
        trade_c = 1'b0;
        cnt_c   = cnt_q;

        if (cnt_q != '0) begin
            cnt_c = cnt_q - CNT_ONE;
        end else begin
            unique case (pos_q)
                FLAT: begin
                    if (score_c > ENTRY_TH) begin
                        pos_c = LONG;
                    end else if (score_c < NEG_ENTRY_TH) begin
                        pos_c = SHORT;
                    end
                end
                LONG: begin
                    if (score_c < EXIT_TH) begin
                        pos_c = FLAT;
                    end
                end
                SHORT: begin
                    if (score_c > NEG_EXIT_TH) begin
                        pos_c = FLAT;
                    end
                end
                default: pos_c = FLAT;
            endcase

            if (pos_c != pos_q) begin
                trade_c = 1'b1;
                cnt_c   = CNT_LOAD;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            score_q     <= Q_ZERO;
            pos_q       <= FLAT;
            trade_q     <= 1'b0;
            cnt_q       <= '0;
        end else if (accept) begin
            out_valid_q <= 1'b1;
            score_q     <= score_c;
            pos_q       <= pos_c;
            trade_q     <= trade_c;
            cnt_q       <= cnt_c;
        end else if (consume) begin
            out_valid_q <= 1'b0;
        end
    end

    assign bus.in_ready  = ready;
    assign bus.out_valid = out_valid_q;
    assign bus.score_out = score_q;
    assign bus.pos_out   = pos_q;
    assign bus.trade_out = trade_q;

endmodule
